// File: rtl/pipeline_controller.sv
// pipeline_controller: sequencer for the 4-stage MAC pipeline; optional perf counters via PIPELINE_CTRL_PERF_EN
module pipeline_controller #(
  parameter int CHUNK_W  = 16,
  parameter int NEURON_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHUNK_W-1:0]  num_chunks,
  input  logic [NEURON_W-1:0] num_neurons,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                stage_1_en,
  output logic                stage_2_en,
  output logic                stage_3_en,
  output logic                stage_4_en,
  output logic                accumulatorReset,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NEURON_W-1:0] res_neuron_idx,
  output logic                res_last
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_stall_cycles
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t              state_q;
  logic [CHUNK_W-1:0]  chunks_q, chunk_cnt_q;
  logic [NEURON_W-1:0] neurons_q, neuron_cnt_q, idx_q;
  logic [2:0]          v_q, t_q;
  logic                res_valid_q;
  logic                adv, start_ok, in_fire, res_fire, last_beat, last_neuron;
  assign adv              = !res_valid_q;
  assign start_ok         = state_q == IDLE && start;
  assign in_ready         = state_q == RUN && adv;
  assign in_fire          = in_valid && in_ready;
  assign res_fire         = res_valid_q && res_ready;
  assign last_beat        = chunk_cnt_q == chunks_q - CHUNK_W'(1);
  assign last_neuron      = neuron_cnt_q == neurons_q - NEURON_W'(1);
  assign stage_1_en       = in_fire;
  assign stage_2_en       = adv && v_q[0];
  assign stage_3_en       = adv && v_q[1];
  assign stage_4_en       = adv && v_q[2];
  assign accumulatorReset = start_ok || res_fire;
  assign res_valid        = res_valid_q;
  assign res_neuron_idx   = idx_q;
  assign res_last         = res_valid_q && idx_q == neurons_q - NEURON_W'(1);
  assign busy             = state_q != IDLE;
  assign done             = state_q == DONE;
  // Job FSM, beat/neuron counters, stage valid/tag shift and result hold
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      chunks_q     <= '0;
      neurons_q    <= '0;
      chunk_cnt_q  <= '0;
      neuron_cnt_q <= '0;
      idx_q        <= '0;
      v_q          <= '0;
      t_q          <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q      <= (num_chunks == '0 || num_neurons == '0) ? DONE : RUN;
          chunks_q     <= num_chunks;
          neurons_q    <= num_neurons;
          chunk_cnt_q  <= '0;
          neuron_cnt_q <= '0;
          idx_q        <= '0;
        end
        RUN:   state_q <= (in_fire && last_beat && last_neuron) ? DRAIN : RUN;
        DRAIN: state_q <= (res_fire && res_last) ? DONE : DRAIN;
        DONE:  state_q <= IDLE;
      endcase
      if (in_fire) begin
        chunk_cnt_q  <= last_beat ? '0 : chunk_cnt_q + CHUNK_W'(1);
        neuron_cnt_q <= last_beat ? neuron_cnt_q + NEURON_W'(1) : neuron_cnt_q;
      end
      if (adv) begin
        v_q <= {v_q[1:0], in_fire};
        t_q <= {t_q[1:0], in_fire && last_beat};
        res_valid_q <= v_q[2] && t_q[2];
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
        idx_q       <= res_last ? '0 : idx_q + NEURON_W'(1);
      end
    end
  end
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] busy_cyc_q, stall_cyc_q;
  assign perf_busy_cycles  = busy_cyc_q;
  assign perf_stall_cycles = stall_cyc_q;
  // Saturating activity counters, restarted with each job
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      busy_cyc_q  <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (busy && !(&busy_cyc_q)) busy_cyc_q <= busy_cyc_q + 32'd1;
      if (state_q == RUN && in_valid && !in_ready && !(&stall_cyc_q)) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed cycle-trace checks of the MAC pipeline sequencer
module tb_pipeline_controller;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [15:0] num_chunks = '0, num_neurons = '0, res_neuron_idx;
  logic        busy, done, in_ready, s1, s2, s3, s4, acc_rst, res_valid, res_last;
  int          n_chk = 0, n_fail = 0;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks), .num_neurons(num_neurons),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .stage_1_en(s1), .stage_2_en(s2), .stage_3_en(s3), .stage_4_en(s4),
    .accumulatorReset(acc_rst), .res_valid(res_valid), .res_ready(res_ready),
    .res_neuron_idx(res_neuron_idx), .res_last(res_last)
`ifdef PIPELINE_CTRL_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, " busy"}, 32'(busy), 0);
    check({nm, " done"}, 32'(done), 0);
    check({nm, " in_ready"}, 32'(in_ready), 0);
    check({nm, " stages"}, 32'({s1, s2, s3, s4}), 0);
    check({nm, " acc_rst"}, 32'(acc_rst), 0);
    check({nm, " res_valid"}, 32'(res_valid), 0);
    check({nm, " res_last"}, 32'(res_last), 0);
    check({nm, " idx"}, 32'(res_neuron_idx), 0);
  endtask

  // Bit i of each pattern is the value in cycle i; start is pulsed in cycle 0.
  task automatic run_case(input string nm, input int ncyc, input logic [15:0] nc, input logic [15:0] nn,
                          input logic [31:0] vin, input logic [31:0] rr,
                          input logic [31:0] e_ir, input logic [31:0] e_s1, input logic [31:0] e_s2,
                          input logic [31:0] e_s3, input logic [31:0] e_s4, input logic [31:0] e_ar,
                          input logic [31:0] e_rv, input logic [31:0] e_busy, input logic [31:0] e_done);
    int idx = 0;
    num_chunks  = nc;
    num_neurons = nn;
    for (int i = 0; i < ncyc; i++) begin
      start     = (i == 0);
      in_valid  = vin[i];
      res_ready = rr[i];
      #1;
      check($sformatf("%s c%0d in_ready", nm, i), 32'(in_ready), 32'(e_ir[i]));
      check($sformatf("%s c%0d stage_1_en", nm, i), 32'(s1), 32'(e_s1[i]));
      check($sformatf("%s c%0d stage_2_en", nm, i), 32'(s2), 32'(e_s2[i]));
      check($sformatf("%s c%0d stage_3_en", nm, i), 32'(s3), 32'(e_s3[i]));
      check($sformatf("%s c%0d stage_4_en", nm, i), 32'(s4), 32'(e_s4[i]));
      check($sformatf("%s c%0d acc_rst", nm, i), 32'(acc_rst), 32'(e_ar[i]));
      check($sformatf("%s c%0d res_valid", nm, i), 32'(res_valid), 32'(e_rv[i]));
      check($sformatf("%s c%0d busy", nm, i), 32'(busy), 32'(e_busy[i]));
      check($sformatf("%s c%0d done", nm, i), 32'(done), 32'(e_done[i]));
      check($sformatf("%s c%0d res_last", nm, i), 32'(res_last), 32'(e_rv[i] && idx == int'(nn) - 1));
      if (e_rv[i]) check($sformatf("%s c%0d idx", nm, i), 32'(res_neuron_idx), 32'(idx));
      if (e_rv[i] && rr[i]) idx++;
      cyc();
    end
    start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovl = 0, s1c = 0, s4c = 0, fires = 0, idx_err = 0, last_err = 0;
    bit seen_done = 0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check_idle("reset");
    run_case("t1", 9, 16'd2, 16'd1, 32'h1FF, 32'h1FF,
             32'h6, 32'h6, 32'hC, 32'h18, 32'h30, 32'h41, 32'h40, 32'hFE, 32'h80);
    run_case("t2", 17, 16'd1, 16'd3, 32'h1FFFF, 32'h1FC00,
             32'hE, 32'hE, 32'h1C, 32'h818, 32'h2810, 32'h5401, 32'h57E0, 32'hFFFE, 32'h8000);
    run_case("zero", 3, 16'd0, 16'd5, 32'h7, 32'h7,
             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h2, 32'h2);
    run_case("tog", 14, 16'd4, 16'd1, 32'hAAAA, 32'h3FFF,
             32'hFE, 32'hAA, 32'h154, 32'h2A8, 32'h550, 32'h801, 32'h800, 32'h1FFE, 32'h1000);
    num_chunks = 16'd3; num_neurons = 16'd2;
    start = 1'b1; in_valid = 1'b1; res_ready = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    check("rst pre stage_4_en", 32'(s4), 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check_idle("midrst");
    run_case("t1b", 9, 16'd2, 16'd1, 32'h1FF, 32'h1FF,
             32'h6, 32'h6, 32'hC, 32'h18, 32'h30, 32'h41, 32'h40, 32'hFE, 32'h80);
    num_chunks = 16'd3; num_neurons = 16'd4;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 600 && !seen_done; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
      #1;
      if (acc_rst && s4) ovl++;
      s1c += int'(s1);
      s4c += int'(s4);
      if (res_valid && res_ready) begin
        if (int'(res_neuron_idx) != fires) idx_err++;
        if (res_last != (fires == 3)) last_err++;
        fires++;
      end
      if (done) seen_done = 1;
      cyc();
    end
    in_valid = 1'b0; res_ready = 1'b0;
    check("rand acc_rst with stage_4_en", 32'(ovl), 0);
    check("rand stage_1_en count", 32'(s1c), 12);
    check("rand stage_4_en count", 32'(s4c), 12);
    check("rand res_fire count", 32'(fires), 4);
    check("rand idx order", 32'(idx_err), 0);
    check("rand res_last", 32'(last_err), 0);
    check("rand done seen", 32'(seen_done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
